// File: rtl/sda_rx.sv
// sda_rx: receiver for the two-wire scl/sda link.
// Synchronizes scl/sda into the sclk domain and detects START, STOP and scl
// rising edges. Each NBITS-bit frame (MSB first) is delivered on data with a
// one-cycle valid pulse, mirrored as a one-hot vector on outhigh.
// Framing problems produce a one-cycle err pulse.
//
// Handshake: there is no backpressure. valid is a one-sclk strobe that marks
// the cycle in which data/outhigh take a new value. err is a one-sclk strobe
// for a discarded frame. The two strobes are never high together.
module sda_rx #(
    parameter int NBITS       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic [NBITS-1:0]      data,
    output logic                  valid,
    output logic [2**NBITS-1:0]   outhigh,
    output logic                  err,
    output logic                  busy
);

    // The counter counts 0..NBITS+1. Its upper values mean "all data bits
    // taken" (NBITS) and "stop-setup clock seen" (NBITS+1).
    localparam int CW = $clog2(NBITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NBITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;
    logic                   sda_s;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [NBITS-1:0]       sh_q;
    logic [NBITS-1:0]       data_q;
    logic [2**NBITS-1:0]    outhigh_q;
    logic [2**NBITS-1:0]    outhigh_d;
    logic                   valid_q;
    logic                   err_q;
    logic                   busy_q;

    logic                   start_det;
    logic                   stop_det;
    logic                   rise_det;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START and STOP are sda edges while scl stays high. RISE is an scl
    // rising edge; it can never coincide with START or STOP.
    assign start_det = scl_q & scl_s & sda_q & ~sda_s;
    assign stop_det  = scl_q & scl_s & ~sda_q & sda_s;
    assign rise_det  = ~scl_q & scl_s;

    // Synchronizer chains plus one history stage for edge detection.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            scl_q      <= 1'b0;
            sda_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_q      <= scl_s;
            sda_q      <= sda_s;
        end
    end

    // One-hot decode of the word about to be delivered.
    always_comb begin
        outhigh_d       = '0;
        outhigh_d[sh_q] = 1'b1;
    end

    // Frame FSM with registered outputs; valid/err default low every cycle.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            outhigh_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A STOP without a START, or stray clocks, are ignored.
                    if (start_det) begin
                        state_q <= RECV;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RECV: begin
                    if (start_det) begin
                        // Repeated start aborts the partial frame and restarts.
                        err_q <= 1'b1;
                        cnt_q <= '0;
                        sh_q  <= '0;
                    end else if (stop_det) begin
                        if (cnt_q >= CNT_FULL) begin
                            data_q    <= sh_q;
                            outhigh_q <= outhigh_d;
                            valid_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (rise_det) begin
                        if (cnt_q == CNT_MAX) begin
                            // Too many clocks: abandon; the later STOP lands in IDLE.
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            if (cnt_q < CNT_FULL) begin
                                sh_q <= {sh_q[NBITS-2:0], sda_s};
                            end
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data    = data_q;
    assign outhigh = outhigh_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sda_rx.sv
// Directed bench for sda_rx: bus-level driver tasks, a negedge monitor that
// counts strobes, and one task per scenario with inline comparisons.
module tb_sda_rx;

    localparam int NBITS = 4;

    logic                sclk;
    logic                rst;
    logic                scl;
    logic                sda;
    logic [NBITS-1:0]    data;
    logic                valid;
    logic [2**NBITS-1:0] outhigh;
    logic                err;
    logic                busy;

    int total = 0;
    int bad   = 0;

    // Monitor state
    int  valid_cnt = 0;
    int  err_cnt   = 0;
    time last_valid_time = 0;
    time stop_time = 0;
    bit  both_seen = 0;
    bit  wide_seen = 0;
    bit  prev_valid = 0;
    bit  prev_err = 0;

    sda_rx #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
        .sclk    (sclk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .data    (data),
        .valid   (valid),
        .outhigh (outhigh),
        .err     (err),
        .busy    (busy)
    );

    // Clock: 10 time-unit period, posedge active.
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Monitor samples on the inactive edge.
    always @(negedge sclk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            last_valid_time = $time;
            if (prev_valid) wide_seen = 1;
        end
        if (err === 1'b1) begin
            err_cnt++;
            if (prev_err) wide_seen = 1;
        end
        if (valid === 1'b1 && err === 1'b1) both_seen = 1;
        prev_valid = (valid === 1'b1);
        prev_err   = (err === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // START from either idle (scl high) or mid-frame (scl low).
    task automatic bus_start();
        sda = 1'b1; wait_cyc(2);
        scl = 1'b1; wait_cyc(4);
        sda = 1'b0; wait_cyc(4);
        scl = 1'b0; wait_cyc(2);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    wait_cyc(2);
        scl = 1'b1; wait_cyc(4);
        scl = 1'b0; wait_cyc(2);
    endtask

    // STOP includes the stop-setup clock with sda low.
    task automatic bus_stop();
        sda = 1'b0; wait_cyc(2);
        scl = 1'b1; wait_cyc(4);
        sda = 1'b1; stop_time = $time; wait_cyc(6);
    endtask

    task automatic send_frame(input logic [NBITS-1:0] w);
        bus_start();
        for (int i = NBITS - 1; i >= 0; i--) bus_bit(w[i]);
        bus_stop();
    endtask

    task automatic check_zero_outputs(input string tag);
        total++;
        if (data !== '0 || outhigh !== '0 || valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: data=%h outhigh=%h valid=%b err=%b busy=%b, required all 0",
                     tag, data, outhigh, valid, err, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; scl = 1'b1; sda = 1'b1;
        wait_cyc(3);
        check_zero_outputs("reset_hold");
        rst = 1'b1;
        wait_cyc(4);
        check_zero_outputs("after_reset");
    endtask

    task automatic test_frame();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_after_start: got %b required 1", busy);
        end
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        bus_stop();
        total++;
        if (valid_cnt - v0 !== 1) begin
            bad++; $display("FAIL frame_valid_count: got %0d required 1", valid_cnt - v0);
        end
        total++;
        if (last_valid_time - stop_time !== 30) begin
            bad++; $display("FAIL frame_latency: got %0t required 30", last_valid_time - stop_time);
        end
        total++;
        if (data !== 4'hB) begin
            bad++; $display("FAIL frame_data: got %h required b", data);
        end
        total++;
        if (outhigh !== 16'h0800) begin
            bad++; $display("FAIL frame_outhigh: got %h required 0800", outhigh);
        end
        total++;
        if (err_cnt - e0 !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL frame_err_busy: err_pulses=%0d busy=%b required 0/0", err_cnt - e0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_frame(4'h0);
        total++;
        if (data !== 4'h0 || outhigh !== 16'h0001) begin
            bad++; $display("FAIL b2b_first: data=%h outhigh=%h required 0/0001", data, outhigh);
        end
        wait_cyc(4);
        send_frame(4'hF);
        total++;
        if (data !== 4'hF || outhigh !== 16'h8000) begin
            bad++; $display("FAIL b2b_second: data=%h outhigh=%h required f/8000", data, outhigh);
        end
        total++;
        if (valid_cnt - v0 !== 2) begin
            bad++; $display("FAIL b2b_valid_count: got %0d required 2", valid_cnt - v0);
        end
    endtask

    task automatic test_short_frame();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        bus_bit(1'b0); bus_bit(1'b1);
        bus_stop();
        total++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            bad++; $display("FAIL short_strobes: err=%0d valid=%0d required 1/0", err_cnt - e0, valid_cnt - v0);
        end
        total++;
        if (data !== 4'hF || outhigh !== 16'h8000) begin
            bad++; $display("FAIL short_hold: data=%h outhigh=%h required f/8000", data, outhigh);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL short_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_repeated_start();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
        bus_start();
        total++;
        if (err_cnt - e0 !== 1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstart_err: err=%0d busy=%b required 1/1", err_cnt - e0, busy);
        end
        bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        total++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 1) begin
            bad++; $display("FAIL rstart_strobes: valid=%0d err=%0d required 1/1", valid_cnt - v0, err_cnt - e0);
        end
        total++;
        if (data !== 4'h6 || outhigh !== 16'h0040) begin
            bad++; $display("FAIL rstart_data: data=%h outhigh=%h required 6/0040", data, outhigh);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b1);
        rst = 1'b0;
        wait_cyc(1);
        check_zero_outputs("midreset_enter");
        wait_cyc(2);
        check_zero_outputs("midreset_hold");
        rst = 1'b1;
        wait_cyc(2);
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(4'h3);
        total++;
        if (data !== 4'h3 || outhigh !== 16'h0008) begin
            bad++; $display("FAIL midreset_data: data=%h outhigh=%h required 3/0008", data, outhigh);
        end
        total++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
            bad++; $display("FAIL midreset_strobes: valid=%0d err=%0d required 1/0", valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_strobe_shape();
        total++;
        if (both_seen !== 1'b0 || wide_seen !== 1'b0) begin
            bad++; $display("FAIL strobe_shape: overlap=%b wide=%b required 0/0", both_seen, wide_seen);
        end
    endtask

    initial begin
        rst = 1'b0; scl = 1'b1; sda = 1'b1;
        test_reset();
        test_frame();
        test_back_to_back();
        test_short_frame();
        test_repeated_start();
        test_reset_mid_frame();
        test_strobe_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
